serial_add_ctrl: RTL and testbench

- Bit-serial adder controller that sequences one 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands.
- The cell has ports a, b, cin, sum and cout, and is instantiated inside this block.
- The block latches the operands, shifts one bit per clock through the cell, and keeps the carry in a flip-flop.
- It provides a start/busy/done handshake to the surrounding arithmetic unit.

---
 rtl/serial_add_ctrl.sv | 92 +++++++++
 tb/tb_serial_add_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one full-adder cell over WIDTH clocks with start/busy/done handshake.
// Optional subtract mode when SERIAL_ADD_SUB_EN is defined (adds port sub).
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic carry, sub_r, sub_in, s, c;
`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif
  // subtraction is A + ~B + 1: invert the B bit, carry forced to 1 at start
  fa_cell u_cell (.a(a_sr[0]), .b(b_sr[0] ^ sub_r), .cin(carry), .sum(s), .cout(c));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_sr  <= op_a;
          b_sr  <= op_b;
          carry <= sub_in ? 1'b1 : cin_init;
          sub_r <= sub_in;
          cnt   <= '0;
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: begin
          result <= {s, result[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= c;
            ovf   <= carry ^ c;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: table vectors, random ops vs arithmetic model, and handshake corner sequences.
module tb_serial_add_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin_init = 1'b0;
  logic [7:0] op_a = '0, op_b = '0;
`ifdef SERIAL_ADD_SUB_EN
  logic sub = 1'b0;
`endif
  logic busy, done, cout, ovf;
  logic [7:0] result;
  int n_cmp = 0, n_bad = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin_init(cin_init),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic ci, s;
    logic [7:0] r;
    logic c, v;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] a, b, input logic ci, s);
    logic [7:0] bb;
    logic [8:0] t;
    bb = s ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + {8'd0, s ? 1'b1 : ci};
    return {(a[7] == bb[7]) && (t[7] != a[7]), t};
  endfunction

  task automatic run_check(input string n, input logic [7:0] a, b, input logic ci, s,
                           input logic [7:0] er, input logic ec, ev);
    int lat, bcnt;
    @(negedge clk);
    op_a = a; op_b = b; cin_init = ci; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`endif
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    chk({n, " latency"}, lat, 8);
    chk({n, " busy_cycles"}, bcnt, 8);
    chk({n, " result"}, result, er);
    chk({n, " cout"}, cout, ec);
    chk({n, " ovf"}, ovf, ev);
    @(negedge clk);
    chk({n, " done_pulse"}, done, 0);
  endtask

  initial begin
    logic [9:0] m;
    int dn, br;
    logic pb;
    tbl.push_back('{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
    tbl.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    tbl.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    tbl.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
    tbl.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0});
`endif
    repeat (2) @(negedge clk);
    chk("reset outputs", {busy, done, cout, ovf, result}, 0);
    rst_n = 1'b1;
    foreach (tbl[i]) run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s,
                               tbl[i].r, tbl[i].c, tbl[i].v);
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a, b;
      logic ci, s;
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      m = model(a, b, ci, s);
      run_check($sformatf("rnd%0d", i), a, b, ci, s, m[7:0], m[8], m[9]);
    end
    // start while busy must be ignored
    @(negedge clk);
    op_a = 8'h3C; op_b = 8'h05; cin_init = 1'b0; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op_a = 8'h11; op_b = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0; br = 0; pb = busy;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy && !pb) br++;
      pb = busy;
    end
    chk("busy_start result", result, 8'h41);
    chk("busy_start done_count", dn, 1);
    chk("busy_start busy_rise", br, 0);
    // asynchronous reset in the middle of a run
    @(negedge clk);
    op_a = 8'hFF; op_b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", {busy, done, cout, ovf, result}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("after reset no done", dn, 0);
    run_check("post_reset", 8'h0A, 8'h0A, 1'b0, 1'b0, 8'h14, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
